// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store, with one
// outstanding transaction, response routing and stale-fetch suppression.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              if_flush_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   input  logic [3:0]        d_be_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [3:0]        mem_be_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o,
   output logic              protocol_err_o
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t            r_state;
   logic              r_owner;
   logic              r_drop;
   logic [CNT_W-1:0]  r_starve_cnt;
   logic              r_if_gnt, r_d_gnt, r_if_rvalid, r_d_rvalid;
   logic [DATA_W-1:0] r_if_rdata, r_d_rdata;
   logic              r_mem_req, r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [3:0]        r_mem_be;
   logic              r_protocol_err;

   logic w_if_elig, w_starved, w_pick_d, w_pick_if, w_if_kill;

   // A flush in the sampling cycle makes the fetch ineligible so the stale PC is never issued.
   assign w_if_elig = if_req_i & ~if_flush_i;
   assign w_starved = (r_starve_cnt == CNT_MAX) & w_if_elig;
   assign w_pick_d  = d_req_i & ~w_starved;
   assign w_pick_if = w_if_elig & ~w_pick_d;
   assign w_if_kill = r_drop | if_flush_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state        <= S_IDLE;
         r_owner        <= OWN_IF;
         r_drop         <= 1'b0;
         r_starve_cnt   <= '0;
         r_if_gnt       <= 1'b0;
         r_d_gnt        <= 1'b0;
         r_if_rvalid    <= 1'b0;
         r_d_rvalid     <= 1'b0;
         r_if_rdata     <= '0;
         r_d_rdata      <= '0;
         r_mem_req      <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
         r_mem_be       <= 4'h0;
         r_protocol_err <= 1'b0;
      end else begin
         // NOTE: pulses default low here and are overridden below; with <= the last write wins cleanly.
         r_if_gnt    <= 1'b0;
         r_d_gnt     <= 1'b0;
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;

         if (mem_rvalid_i && r_state != S_RESP) r_protocol_err <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_pick_d) begin
                  r_owner     <= OWN_D;
                  r_d_gnt     <= 1'b1;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= d_we_i;
                  r_mem_addr  <= d_addr_i;
                  r_mem_wdata <= d_wdata_i;
                  r_mem_be    <= d_be_i;
                  r_drop      <= 1'b0;
                  r_state     <= S_REQ;
                  if (!if_req_i)                r_starve_cnt <= '0;
                  else if (r_starve_cnt != CNT_MAX) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
               end else if (w_pick_if) begin
                  r_owner      <= OWN_IF;
                  r_if_gnt     <= 1'b1;
                  r_mem_req    <= 1'b1;
                  r_mem_we     <= 1'b0;
                  r_mem_addr   <= if_addr_i;
                  r_mem_wdata  <= '0;
                  r_mem_be     <= 4'hF;
                  r_drop       <= 1'b0;
                  r_starve_cnt <= '0;
                  r_state      <= S_REQ;
               end
            end
            S_REQ: begin
               if (if_flush_i && r_owner == OWN_IF) r_drop <= 1'b1;
               if (mem_gnt_i) begin
                  r_mem_req <= 1'b0;
                  r_state   <= S_RESP;
               end
            end
            S_RESP: begin
               if (mem_rvalid_i) begin
                  r_state <= S_IDLE;
                  if (r_owner == OWN_D) begin
                     r_d_rdata  <= mem_rdata_i;
                     r_d_rvalid <= 1'b1;
                  end else if (!w_if_kill) begin
                     r_if_rdata  <= mem_rdata_i;
                     r_if_rvalid <= 1'b1;
                  end
               end else if (if_flush_i && r_owner == OWN_IF) begin
                  r_drop <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign if_gnt_o       = r_if_gnt;
   assign if_rvalid_o    = r_if_rvalid;
   assign if_rdata_o     = r_if_rdata;
   assign d_gnt_o        = r_d_gnt;
   assign d_rvalid_o     = r_d_rvalid;
   assign d_rdata_o      = r_d_rdata;
   assign mem_req_o      = r_mem_req;
   assign mem_we_o       = r_mem_we;
   assign mem_addr_o     = r_mem_addr;
   assign mem_wdata_o    = r_mem_wdata;
   assign mem_be_o       = r_mem_be;
   assign busy_o         = (r_state != S_IDLE);
   assign protocol_err_o = r_protocol_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both requesters and the
// memory, cycle by cycle, and compares against hand-computed values.
module tb_mem_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i, if_flush_i, d_req_i, d_we_i;
   logic [31:0] if_addr_i, d_addr_i, d_wdata_i;
   logic [3:0]  d_be_i;
   logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o;
   logic [31:0] if_rdata_o, d_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        busy_o, protocol_err_o;

   int vec_cnt = 0;
   int err_cnt = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
      .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .protocol_err_o(protocol_err_o)
   );

   always #5 clk_i = ~clk_i;

   // Outputs are read 1 time unit after the rising edge; inputs are changed there too.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Entered in the cycle the grant is visible; leaves in the cycle rvalid_o is visible.
   task automatic mem_xact(input logic [31:0] data);
      mem_gnt_i = 1'b1;
      step();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = data;
      step();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      if_req_i = 0; if_flush_i = 0; if_addr_i = '0;
      d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
      step(); step();
      vec_cnt++; if ({if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o} !== 4'b0) begin err_cnt++; $display("FAIL reset_pulses: got %b want 0000", {if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o}); end
      vec_cnt++; if ({mem_req_o, busy_o, protocol_err_o} !== 3'b0) begin err_cnt++; $display("FAIL reset_status: got %b want 000", {mem_req_o, busy_o, protocol_err_o}); end
      vec_cnt++; if (mem_addr_o !== 32'h0 || mem_be_o !== 4'h0) begin err_cnt++; $display("FAIL reset_cmd: got addr %h be %h want 0/0", mem_addr_o, mem_be_o); end
      rst_i = 1'b1;
   endtask

   task automatic test_lone_fetch();
      if_req_i = 1; if_addr_i = 32'h100;
      step();
      vec_cnt++; if (if_gnt_o !== 1'b1 || d_gnt_o !== 1'b0) begin err_cnt++; $display("FAIL fetch_gnt: got if %b d %b want 1/0", if_gnt_o, d_gnt_o); end
      vec_cnt++; if ({mem_req_o, busy_o, mem_we_o} !== 3'b110) begin err_cnt++; $display("FAIL fetch_req: got req/busy/we %b want 110", {mem_req_o, busy_o, mem_we_o}); end
      vec_cnt++; if (mem_addr_o !== 32'h100 || mem_be_o !== 4'hF || mem_wdata_o !== 32'h0) begin err_cnt++; $display("FAIL fetch_cmd: got %h/%h/%h want 100/f/0", mem_addr_o, mem_be_o, mem_wdata_o); end
      if_req_i = 0; if_addr_i = 32'hFFFF_FFF0;
      mem_gnt_i = 1;
      step();
      vec_cnt++; if (if_gnt_o !== 1'b0 || mem_req_o !== 1'b0 || busy_o !== 1'b1) begin err_cnt++; $display("FAIL fetch_resp_wait: got gnt/req/busy %b%b%b want 001", if_gnt_o, mem_req_o, busy_o); end
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0050_0093;
      step();
      mem_rvalid_i = 0; mem_rdata_i = '0;
      vec_cnt++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h0050_0093) begin err_cnt++; $display("FAIL fetch_rdata: got %b %h want 1 00500093", if_rvalid_o, if_rdata_o); end
      vec_cnt++; if (busy_o !== 1'b0 || d_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL fetch_idle: got busy %b drv %b want 0/0", busy_o, d_rvalid_o); end
      step();
      vec_cnt++; if (if_rvalid_o !== 1'b0 || if_rdata_o !== 32'h0050_0093) begin err_cnt++; $display("FAIL fetch_hold: got %b %h want 0 00500093", if_rvalid_o, if_rdata_o); end
   endtask

   task automatic test_contention();
      if_req_i = 1; if_addr_i = 32'h104;
      d_req_i = 1; d_we_i = 0; d_addr_i = 32'h2000; d_be_i = 4'hF;
      step();
      vec_cnt++; if (d_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin err_cnt++; $display("FAIL cont_d_first: got d %b if %b want 1/0", d_gnt_o, if_gnt_o); end
      vec_cnt++; if (mem_addr_o !== 32'h2000 || mem_we_o !== 1'b0) begin err_cnt++; $display("FAIL cont_d_cmd: got %h we %b want 2000/0", mem_addr_o, mem_we_o); end
      d_req_i = 0;
      mem_xact(32'h1234_5678);
      vec_cnt++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'h1234_5678 || if_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL cont_d_rdata: got %b %h ifrv %b want 1 12345678 0", d_rvalid_o, d_rdata_o, if_rvalid_o); end
      vec_cnt++; if (if_gnt_o !== 1'b0) begin err_cnt++; $display("FAIL cont_if_early: got %b want 0", if_gnt_o); end
      step();
      vec_cnt++; if (if_gnt_o !== 1'b1 || mem_addr_o !== 32'h104) begin err_cnt++; $display("FAIL cont_if_next: got %b %h want 1 104", if_gnt_o, mem_addr_o); end
      if_req_i = 0;
      mem_xact(32'hCAFE_0001);
      vec_cnt++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hCAFE_0001 || d_rdata_o !== 32'h1234_5678) begin err_cnt++; $display("FAIL cont_if_rdata: got %b %h d %h want 1 cafe0001 12345678", if_rvalid_o, if_rdata_o, d_rdata_o); end
   endtask

   task automatic test_starvation();
      int exp_who[6] = '{1, 1, 1, 1, 2, 1};
      int who;
      if_req_i = 1; if_addr_i = 32'h400;
      d_req_i = 1; d_we_i = 0; d_addr_i = 32'h3000; d_be_i = 4'hF;
      for (int i = 0; i < 6; i++) begin
         step();
         who = (d_gnt_o === 1'b1 ? 1 : 0) + (if_gnt_o === 1'b1 ? 2 : 0);
         vec_cnt++; if (who != exp_who[i]) begin err_cnt++; $display("FAIL starve_grant%0d: got code %0d want %0d (1=D 2=IF)", i, who, exp_who[i]); end
         if (i == 5) begin if_req_i = 0; d_req_i = 0; end
         mem_xact(32'h1000_0000 + i);
         if (i < 5) begin if_req_i = 1; d_req_i = 1; end
      end
   endtask

   task automatic test_flush();
      if_req_i = 1; if_addr_i = 32'h200;
      step();
      vec_cnt++; if (if_gnt_o !== 1'b1) begin err_cnt++; $display("FAIL flush_gnt: got %b want 1", if_gnt_o); end
      if_req_i = 0; mem_gnt_i = 1;
      step();
      mem_gnt_i = 0; if_flush_i = 1;
      step();
      if_flush_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0BAD;
      step();
      mem_rvalid_i = 0; mem_rdata_i = '0;
      vec_cnt++; if (if_rvalid_o !== 1'b0 || if_rdata_o !== 32'h1000_0004) begin err_cnt++; $display("FAIL flush_drop: got %b %h want 0 10000004", if_rvalid_o, if_rdata_o); end
      vec_cnt++; if (busy_o !== 1'b0 || protocol_err_o !== 1'b0) begin err_cnt++; $display("FAIL flush_idle: got busy %b err %b want 0/0", busy_o, protocol_err_o); end
      if_req_i = 1; if_addr_i = 32'h204;
      step();
      vec_cnt++; if (if_gnt_o !== 1'b1 || mem_addr_o !== 32'h204) begin err_cnt++; $display("FAIL flush_next_gnt: got %b %h want 1 204", if_gnt_o, mem_addr_o); end
      if_req_i = 0;
      mem_xact(32'h0000_0013);
      vec_cnt++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h0000_0013) begin err_cnt++; $display("FAIL flush_next_rdata: got %b %h want 1 00000013", if_rvalid_o, if_rdata_o); end
   endtask

   task automatic test_store_wait();
      d_req_i = 1; d_we_i = 1; d_addr_i = 32'h40; d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'b0011;
      step();
      vec_cnt++; if (d_gnt_o !== 1'b1) begin err_cnt++; $display("FAIL store_gnt: got %b want 1", d_gnt_o); end
      d_req_i = 0; d_we_i = 0; d_addr_i = 32'h999; d_wdata_i = '0; d_be_i = 4'hF;
      for (int c = 1; c <= 4; c++) begin
         vec_cnt++; if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b11_0011 || mem_addr_o !== 32'h40 || mem_wdata_o !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL store_hold%0d: got req %b we %b be %h addr %h wd %h want 1 1 3 40 deadbeef", c, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
         if (c == 4) mem_gnt_i = 1;
         step();
      end
      mem_gnt_i = 0;
      vec_cnt++; if (mem_req_o !== 1'b0 || d_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL store_resp_wait: got req %b rv %b want 0/0", mem_req_o, d_rvalid_o); end
      mem_rvalid_i = 1;
      step();
      mem_rvalid_i = 0;
      vec_cnt++; if (d_rvalid_o !== 1'b1 || if_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL store_ack: got d %b if %b want 1/0", d_rvalid_o, if_rvalid_o); end
   endtask

   task automatic test_reset_mid();
      vec_cnt++; if (protocol_err_o !== 1'b0) begin err_cnt++; $display("FAIL err_before: got %b want 0", protocol_err_o); end
      if_req_i = 1; if_addr_i = 32'h300;
      step();
      if_req_i = 0; mem_gnt_i = 1;
      step();
      mem_gnt_i = 0; rst_i = 0;
      step();
      vec_cnt++; if ({if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, mem_req_o, busy_o, protocol_err_o} !== 7'b0) begin err_cnt++; $display("FAIL rstmid_outs: got %b want 0000000", {if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, mem_req_o, busy_o, protocol_err_o}); end
      vec_cnt++; if (if_rdata_o !== 32'h0 || d_rdata_o !== 32'h0 || mem_addr_o !== 32'h0) begin err_cnt++; $display("FAIL rstmid_data: got %h %h %h want 0 0 0", if_rdata_o, d_rdata_o, mem_addr_o); end
      rst_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h5555_AAAA;
      step();
      mem_rvalid_i = 0; mem_rdata_i = '0;
      vec_cnt++; if (protocol_err_o !== 1'b1 || if_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0) begin err_cnt++; $display("FAIL rstmid_stale: got err %b ifrv %b drv %b want 1 0 0", protocol_err_o, if_rvalid_o, d_rvalid_o); end
      step();
      vec_cnt++; if (protocol_err_o !== 1'b1 || if_rdata_o !== 32'h0) begin err_cnt++; $display("FAIL rstmid_sticky: got err %b rdata %h want 1 0", protocol_err_o, if_rdata_o); end
   endtask

   initial begin
      test_reset();
      test_lone_fetch();
      test_contention();
      test_starvation();
      test_flush();
      test_store_wait();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the IF-stage instruction fetch and the MEM-stage load/store. It grants one requester at a time and tracks a single outstanding transaction. It routes the response back to its owner and discards fetch responses made stale by a branch redirect. It sits between IF/MEM and the memory model, replacing the separate instruction and data ports.

## Interface
- ADDR_W, 32, address width (`SYS_ADDR_SPACE)
- DATA_W, 32, data width (`GPR_WIDTH)
- STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending (≥1)

- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-low
- if_req_i  in  1  fetch request; held until if_gnt_o
- if_addr_i  in  ADDR_W  fetch address
- if_flush_i  in  1  branch redirect (from branch unit pc_we); invalidates in-flight fetch
- if_gnt_o  out  1  one-cycle fetch grant pulse
- if_rvalid_o  out  1  one-cycle fetch data valid
- if_rdata_o  out  DATA_W  fetched instruction
- d_req_i  in  1  data request; held until d_gnt_o
- d_we_i  in  1  1 = store
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_be_i  in  4  byte enables (from mem_mode/funct3)
- d_gnt_o  out  1  one-cycle data grant pulse
- d_rvalid_o  out  1  one-cycle load data / store ack
- d_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  request to memory, held until mem_gnt_i
- mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  out  1/ADDR_W/DATA_W/4  latched command
- mem_gnt_i  in  1  memory accepted command
- mem_rvalid_i  in  1  memory response (also for stores)
- mem_rdata_i  in  DATA_W  response data
- busy_o  out  1  state ≠ IDLE
- protocol_err_o  out  1  sticky: mem_rvalid_i seen outside RESP

## Operation
- States: IDLE, REQ, RESP. Owner register: IF or D. Drop flag.
- IDLE: sample requests. Eligible IF = if_req_i & ~if_flush_i.
  - Winner: D if d_req_i, unless starve_cnt == STARVE_LIMIT and IF eligible; else IF.
  - On a winner: latch the command into the mem_* registers, set owner, pulse the winner's gnt_o next cycle, go to REQ, clear drop.
- Starvation counter: increments on a D grant while if_req_i=1; clears on an IF grant or a D grant with if_req_i=0. It saturates at STARVE_LIMIT.
- REQ: mem_req_o=1 with a stable command. On mem_gnt_i, go to RESP. A transaction cannot be aborted after grant.
- RESP: on mem_rvalid_i, register mem_rdata_i into the owner's rdata and pulse the owner's rvalid_o next cycle, then go to IDLE.
  - If owner=IF and drop=1 (or if_flush_i this cycle), suppress if_rvalid_o.
- if_flush_i while owner=IF in REQ or RESP sets drop. The flush has no effect when owner=D.
- Fetch commands: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
- mem_rvalid_i in IDLE/REQ is ignored for routing and sets protocol_err_o.
- Reset values (rst_i=0 at an edge):
  - State IDLE; all gnt/rvalid/mem_req/busy/protocol_err outputs 0.
  - rdata/mem_* registers 0; starve_cnt 0; drop 0.
- Reset mid-transaction abandons the transaction. A later stale mem_rvalid_i sets protocol_err_o.

## Timing
- Cycle 0: request sampled in IDLE.
- Cycle 1: gnt_o pulse, mem_req_o=1, busy_o=1.
- With mem_gnt_i in cycle 1 and mem_rvalid_i in cycle 2: rvalid_o and rdata in cycle 3, state IDLE in cycle 3, next request sampled in cycle 3.
- Minimum turnaround is 3 cycles per transaction; each memory wait cycle adds 1.
- The requester may drop req or change the address after gnt_o. The arbiter uses only the latched copy.
- gnt_o and rvalid_o are never asserted for both requesters in the same cycle.
- rdata outputs hold their value until the next response for that requester.

## Test plan
- Lone fetch at 0x100, zero-wait memory returning 0x00500093 -> if_gnt_o in cycle 1, mem_addr_o=0x100 with mem_we_o=0, if_rvalid_o with if_rdata_o=0x00500093 in cycle 3.
- if_req_i and d_req_i (load 0x2000) together in IDLE -> D granted first, IF granted in the cycle after d_rvalid_o.
- d_req_i held continuously with if_req_i held, STARVE_LIMIT=4 -> exactly 4 D grants, then 1 IF grant, with the counter cleared.
- Fetch granted, if_flush_i asserted during RESP, mem_rvalid_i arrives -> if_rvalid_o stays 0, next request served normally.
- Store 0xDEADBEEF to 0x40 with d_be_i=4'b0011 and mem_gnt_i delayed 3 cycles -> mem_req_o held with a stable command for 4 cycles, d_rvalid_o follows mem_rvalid_i by 1 cycle.
- rst_i=0 during RESP, then mem_rvalid_i after release -> all outputs 0 after the reset edge, protocol_err_o=1, no rvalid pulse.
